// File: rtl/dll_pkg.sv
// Shared encodings, STP field layout and LCRC constants for the receive-side DLL.
package dll_pkg;

  localparam logic [1:0] DLCMSM_INACTIVE = 2'b00;
  localparam logic [1:0] DLCMSM_INIT     = 2'b01;
  localparam logic [1:0] DLCMSM_ACTIVE   = 2'b10;

  localparam logic [1:0] ACKNAK_IDLE = 2'b00;
  localparam logic [1:0] ACKNAK_ACK  = 2'b01;
  localparam logic [1:0] ACKNAK_NAK  = 2'b10;

  localparam int unsigned DW_W    = 32;
  localparam int unsigned BEAT_DW = 8;

  localparam int unsigned STP_TYPE_LSB = 0;
  localparam int unsigned STP_TYPE_W   = 4;
  localparam int unsigned STP_LEN_LSB  = 4;
  localparam int unsigned STP_LEN_W    = 11;
  localparam int unsigned STP_SEQ_LSB  = 16;
  localparam int unsigned SEQ_W        = 12;
  localparam logic [3:0]  STP_TYPE     = 4'hF;

  localparam logic [31:0] LCRC_POLY = 32'h04C1_1DB7;
  localparam logic [31:0] LCRC_INIT = 32'hFFFF_FFFF;

  typedef logic [SEQ_W-1:0] seq_t;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BODY = 2'd1,
    S_DROP = 2'd2
  } rx_state_t;

endpackage

// File: rtl/dll_lcrc32_dw8.sv
// Combinational CRC-32 update over up to eight DWs of one beat, DW0 first, bit 31 first.
module dll_lcrc32_dw8
  import dll_pkg::*;
(
  input  logic [31:0]               crc_in,
  input  logic [BEAT_DW*DW_W-1:0]   data,
  input  logic [BEAT_DW-1:0]        dw_en,
  output logic [31:0]               crc_out
);

  always_comb begin
    crc_out = crc_in;
    for (int k = 0; k < int'(BEAT_DW); k++) begin
      if (dw_en[k]) begin
        for (int b = int'(DW_W) - 1; b >= 0; b--) begin
          crc_out = {crc_out[30:0], 1'b0} ^
                    ((crc_out[31] ^ data[k*int'(DW_W) + b]) ? LCRC_POLY : 32'h0);
        end
      end
    end
  end

endmodule

// File: rtl/dll_rx_tlp_checker.sv
// Receive DLL TLP checker: frames TLPs by STP, checks LCRC and sequence number,
// forwards beats cut-through to the TL and schedules ACK/NAK requests.
module dll_rx_tlp_checker
  import dll_pkg::*;
#(
  parameter int unsigned PIPE_DATA_WIDTH = 256,
  parameter int unsigned MAX_TLP_DW      = 134,
  parameter int unsigned ACK_LATENCY     = 64
) (
  input  logic                       sclk,
  input  logic                       srst,
  input  logic [1:0]                 DLCMSM_i,
  input  logic [PIPE_DATA_WIDTH-1:0] data_i,
  input  logic                       data_valid_i,
  output logic [PIPE_DATA_WIDTH-1:0] tlp_data_o,
  output logic                       tlp_valid_o,
  output logic                       tlp_sop_o,
  output logic                       tlp_eop_o,
  output logic [2:0]                 tlp_last_dw_o,
  output logic                       tlp_ok_o,
  output logic                       tlp_drop_o,
  output logic [15:0]                acknak_seq_num_o,
  output logic [1:0]                 acknak_seq_en_o,
  input  logic                       acknak_ready_i
);

  localparam int unsigned LEN_W = STP_LEN_W;
  localparam int unsigned TMR_W = $clog2(ACK_LATENCY);

  rx_state_t         state_q, state_nxt;
  logic [LEN_W-1:0]  rem_q, rem_nxt, cur_rem, stp_len;
  seq_t              seq_q, seq_nxt, cur_seq, stp_seq, seq_diff;
  seq_t              nrs_q, nrs_nxt;
  logic [31:0]       crc_q, crc_nxt, crc_base, crc_calc, lcrc_dw;
  logic [BEAT_DW-1:0] dw_en;
  logic [2:0]        last_idx;
  logic              active, is_stp, len_bad, beat_eop, crc_good;

  logic              fwd_valid, fwd_sop, eop_decide, len_nak, flush;
  logic              good_ev, dup_ev, nak_ev, nak_req;

  logic              nak_sched_q, nak_sched_nxt;
  logic              tmr_run_q, tmr_run_nxt, tmr_fire;
  logic [TMR_W-1:0]  tmr_cnt_q, tmr_cnt_nxt;
  logic [1:0]        en_nxt, en_base;
  logic              accept;

  // Beat decode: STP fields, remaining length and the LCRC position in this beat
  always_comb begin
    active   = (DLCMSM_i == DLCMSM_ACTIVE);
    is_stp   = (data_i[STP_TYPE_LSB +: STP_TYPE_W] == STP_TYPE);
    stp_len  = data_i[STP_LEN_LSB +: STP_LEN_W];
    stp_seq  = data_i[STP_SEQ_LSB +: SEQ_W];
    len_bad  = (stp_len < LEN_W'(3)) || (stp_len > LEN_W'(MAX_TLP_DW));
    cur_rem  = (state_q == S_IDLE) ? stp_len : rem_q;
    cur_seq  = (state_q == S_IDLE) ? stp_seq : seq_q;
    crc_base = (state_q == S_IDLE) ? LCRC_INIT : crc_q;
    beat_eop = (cur_rem <= LEN_W'(BEAT_DW));
    last_idx = 3'(cur_rem - LEN_W'(1));
    for (int k = 0; k < int'(BEAT_DW); k++) begin
      dw_en[k] = !beat_eop || (LEN_W'(k) < (cur_rem - LEN_W'(1)));
    end
    lcrc_dw  = data_i[{last_idx, 5'd0} +: 32];
    seq_diff = cur_seq - nrs_q;
  end

  dll_lcrc32_dw8 u_lcrc (
    .crc_in  (crc_base),
    .data    (data_i),
    .dw_en   (dw_en),
    .crc_out (crc_calc)
  );

  assign crc_good = ((~crc_calc) == lcrc_dw);

  // Framing FSM: state register
  always_ff @(posedge sclk or posedge srst) begin
    if (srst) state_q <= S_IDLE;
    else      state_q <= state_nxt;
  end

  // Framing FSM: next state and per-beat strobes
  always_comb begin
    state_nxt  = state_q;
    rem_nxt    = rem_q;
    seq_nxt    = seq_q;
    crc_nxt    = crc_q;
    fwd_valid  = 1'b0;
    fwd_sop    = 1'b0;
    eop_decide = 1'b0;
    len_nak    = 1'b0;
    flush      = 1'b0;
    if (!active) begin
      state_nxt = S_IDLE;
      flush     = (state_q == S_BODY);
    end else begin
      case (state_q)
        S_IDLE: begin
          if (data_valid_i && is_stp) begin
            if (len_bad) begin
              // Short bad lengths end in this beat; long ones are swallowed
              len_nak = 1'b1;
              if (!beat_eop) begin
                state_nxt = S_DROP;
                rem_nxt   = cur_rem - LEN_W'(BEAT_DW);
              end
            end else begin
              fwd_valid = 1'b1;
              fwd_sop   = 1'b1;
              if (beat_eop) begin
                eop_decide = 1'b1;
              end else begin
                state_nxt = S_BODY;
                rem_nxt   = cur_rem - LEN_W'(BEAT_DW);
                seq_nxt   = stp_seq;
                crc_nxt   = crc_calc;
              end
            end
          end
        end
        S_BODY: begin
          if (data_valid_i) begin
            fwd_valid = 1'b1;
            if (beat_eop) begin
              eop_decide = 1'b1;
              state_nxt  = S_IDLE;
            end else begin
              rem_nxt = cur_rem - LEN_W'(BEAT_DW);
              crc_nxt = crc_calc;
            end
          end
        end
        S_DROP: begin
          if (data_valid_i) begin
            if (beat_eop) state_nxt = S_IDLE;
            else          rem_nxt   = cur_rem - LEN_W'(BEAT_DW);
          end
        end
        default: state_nxt = S_IDLE;
      endcase
    end
  end

  // TLP verdict at EOP: LCRC first, then sequence distance
  always_comb begin
    good_ev = eop_decide && crc_good && (seq_diff == '0);
    dup_ev  = eop_decide && crc_good && (seq_diff != '0) && seq_diff[SEQ_W-1];
    nak_ev  = (eop_decide && !good_ev && !dup_ev) || len_nak;
    nak_req = nak_ev && !nak_sched_q;
  end

  always_ff @(posedge sclk or posedge srst) begin
    if (srst) begin
      rem_q <= '0;
      seq_q <= '0;
      crc_q <= '0;
    end else begin
      rem_q <= rem_nxt;
      seq_q <= seq_nxt;
      crc_q <= crc_nxt;
    end
  end

  // TL-facing output stage
  always_ff @(posedge sclk or posedge srst) begin
    if (srst) begin
      tlp_data_o    <= '0;
      tlp_valid_o   <= 1'b0;
      tlp_sop_o     <= 1'b0;
      tlp_eop_o     <= 1'b0;
      tlp_last_dw_o <= 3'd0;
      tlp_ok_o      <= 1'b0;
      tlp_drop_o    <= 1'b0;
    end else begin
      tlp_data_o    <= fwd_valid ? data_i : '0;
      tlp_valid_o   <= fwd_valid || flush;
      tlp_sop_o     <= fwd_sop;
      tlp_eop_o     <= eop_decide || flush;
      tlp_last_dw_o <= eop_decide ? last_idx : 3'd0;
      tlp_ok_o      <= good_ev;
      tlp_drop_o    <= (eop_decide && !good_ev) || flush;
    end
  end

  // NRS, NAK suppression, ACK timer and the request register
  always_comb begin
    accept   = (acknak_seq_en_o != ACKNAK_IDLE) && acknak_ready_i;
    tmr_fire = tmr_run_q && (tmr_cnt_q == TMR_W'(ACK_LATENCY - 1));

    nrs_nxt       = good_ev ? nrs_q + seq_t'(1) : nrs_q;
    nak_sched_nxt = nak_sched_q;
    if (good_ev)      nak_sched_nxt = 1'b0;
    else if (nak_req) nak_sched_nxt = 1'b1;

    tmr_run_nxt = tmr_run_q;
    tmr_cnt_nxt = tmr_run_q ? tmr_cnt_q + TMR_W'(1) : tmr_cnt_q;
    if (tmr_fire || accept) begin
      tmr_run_nxt = 1'b0;
      tmr_cnt_nxt = '0;
    end
    if (good_ev && !tmr_run_nxt) begin
      tmr_run_nxt = 1'b1;
      tmr_cnt_nxt = '0;
    end

    // A request raised in the accepting cycle becomes the next pending one
    en_base = accept ? ACKNAK_IDLE : acknak_seq_en_o;
    en_nxt  = en_base;
    if (nak_req)                    en_nxt = ACKNAK_NAK;
    else if (dup_ev || tmr_fire)    en_nxt = (en_base == ACKNAK_NAK) ? ACKNAK_NAK : ACKNAK_ACK;

    if (!active) begin
      nrs_nxt       = '0;
      nak_sched_nxt = 1'b0;
      tmr_run_nxt   = 1'b0;
      tmr_cnt_nxt   = '0;
      en_nxt        = ACKNAK_IDLE;
    end
  end

  always_ff @(posedge sclk or posedge srst) begin
    if (srst) begin
      nrs_q            <= '0;
      nak_sched_q      <= 1'b0;
      tmr_run_q        <= 1'b0;
      tmr_cnt_q        <= '0;
      acknak_seq_en_o  <= ACKNAK_IDLE;
      acknak_seq_num_o <= 16'h0;
    end else begin
      nrs_q            <= nrs_nxt;
      nak_sched_q      <= nak_sched_nxt;
      tmr_run_q        <= tmr_run_nxt;
      tmr_cnt_q        <= tmr_cnt_nxt;
      acknak_seq_en_o  <= en_nxt;
      acknak_seq_num_o <= {4'h0, nrs_nxt - seq_t'(1)};
    end
  end

endmodule

// File: tb/tb_dll_rx_tlp_checker.sv
// Scoreboard bench for dll_rx_tlp_checker: directed TLPs, queued expectations, decoupled monitor.
module tb_dll_rx_tlp_checker;
  import dll_pkg::*;

  logic         sclk = 1'b0;
  logic         srst;
  logic [1:0]   DLCMSM_i;
  logic [255:0] data_i;
  logic         data_valid_i;
  logic [255:0] tlp_data_o;
  logic         tlp_valid_o, tlp_sop_o, tlp_eop_o, tlp_ok_o, tlp_drop_o;
  logic [2:0]   tlp_last_dw_o;
  logic [15:0]  acknak_seq_num_o;
  logic [1:0]   acknak_seq_en_o;
  logic         acknak_ready_i;

  always #5 sclk = ~sclk;

  dll_rx_tlp_checker dut (
    .sclk             (sclk),
    .srst             (srst),
    .DLCMSM_i         (DLCMSM_i),
    .data_i           (data_i),
    .data_valid_i     (data_valid_i),
    .tlp_data_o       (tlp_data_o),
    .tlp_valid_o      (tlp_valid_o),
    .tlp_sop_o        (tlp_sop_o),
    .tlp_eop_o        (tlp_eop_o),
    .tlp_last_dw_o    (tlp_last_dw_o),
    .tlp_ok_o         (tlp_ok_o),
    .tlp_drop_o       (tlp_drop_o),
    .acknak_seq_num_o (acknak_seq_num_o),
    .acknak_seq_en_o  (acknak_seq_en_o),
    .acknak_ready_i   (acknak_ready_i)
  );

  typedef struct packed {
    logic [255:0] data;
    logic         sop;
    logic         eop;
    logic [2:0]   last_dw;
    logic         ok;
    logic         drop;
  } tl_exp_t;

  typedef struct packed {
    logic [1:0]  en;
    logic [15:0] num;
  } an_exp_t;

  localparam logic [31:0] BODY = 32'h1234_5600;
  localparam int MODE_OK = 0, MODE_DROP = 1, MODE_NONE = 2;

  tl_exp_t     tl_q[$];
  an_exp_t     an_q[$];
  logic [31:0] tx_dw [136];
  int          n_checks = 0;
  int          n_fail   = 0;

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference LCRC, byte-at-a-time MSB-first, over tx_dw[0..n-1]
  function automatic logic [31:0] lcrc_of(input int n);
    logic [31:0] c;
    c = 32'hFFFF_FFFF;
    for (int i = 0; i < n; i++) begin
      for (int j = 3; j >= 0; j--) begin
        c = c ^ {tx_dw[i][j*8 +: 8], 24'h0};
        for (int b = 0; b < 8; b++) c = c[31] ? ((c << 1) ^ 32'h04C1_1DB7) : (c << 1);
      end
    end
    return ~c;
  endfunction

  task automatic step(input int n);
    repeat (n) begin
      @(posedge sclk);
      #1;
    end
  endtask

  task automatic drive_beat(input logic [255:0] d);
    data_i       = d;
    data_valid_i = 1'b1;
    @(posedge sclk);
    #1;
    data_valid_i = 1'b0;
    data_i       = '0;
  endtask

  task automatic send_tlp(input int len, input int seq, input bit corrupt, input int mode,
                          input logic [31:0] body, input int max_beats);
    int           nb, ns;
    logic [255:0] beat;
    tl_exp_t      e;
    for (int i = 0; i < 136; i++) tx_dw[i] = 32'h0;
    tx_dw[0] = {4'h0, 12'(seq), 1'b0, 11'(len), 4'hF};
    for (int i = 1; i < len - 1; i++) tx_dw[i] = body + (32'(i) << 16);
    tx_dw[len-1] = lcrc_of(len - 1) ^ (corrupt ? 32'h1 : 32'h0);
    nb = (len + 7) / 8;
    ns = (max_beats > 0 && max_beats < nb) ? max_beats : nb;
    for (int b = 0; b < ns; b++) begin
      for (int k = 0; k < 8; k++) beat[k*32 +: 32] = tx_dw[b*8 + k];
      if (mode != MODE_NONE) begin
        e.data    = beat;
        e.sop     = (b == 0);
        e.eop     = (b == nb - 1);
        e.last_dw = e.eop ? 3'((len - 1) % 8) : 3'd0;
        e.ok      = e.eop && (mode == MODE_OK);
        e.drop    = e.eop && (mode == MODE_DROP);
        tl_q.push_back(e);
      end
      drive_beat(beat);
    end
  endtask

  task automatic link_reset();
    DLCMSM_i = DLCMSM_INACTIVE;
    step(2);
    DLCMSM_i = DLCMSM_INIT;
    step(1);
    DLCMSM_i = DLCMSM_ACTIVE;
    step(1);
  endtask

  task automatic wait_drain(input int bound);
    int c;
    c = 0;
    while ((tl_q.size() != 0 || an_q.size() != 0) && c < bound) begin
      step(1);
      c++;
    end
    check("drain_tl", 256'(tl_q.size()), '0);
    check("drain_acknak", 256'(an_q.size()), '0);
  endtask

  // Monitor: pops the scoreboard whenever the DUT presents a TL beat or an accepted request
  task automatic monitor();
    tl_exp_t e;
    an_exp_t a;
    forever begin
      @(negedge sclk);
      if (!srst) begin
        if (tlp_valid_o) begin
          if (tl_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL tl_unexpected: got sop=%0b eop=%0b ok=%0b drop=%0b, expected no beat",
                     tlp_sop_o, tlp_eop_o, tlp_ok_o, tlp_drop_o);
          end else begin
            e = tl_q.pop_front();
            check("tl_ctl", 256'({tlp_sop_o, tlp_eop_o, tlp_last_dw_o, tlp_ok_o, tlp_drop_o}),
                  256'({e.sop, e.eop, e.last_dw, e.ok, e.drop}));
            check("tl_data", tlp_data_o, e.data);
          end
        end
        if (acknak_seq_en_o != ACKNAK_IDLE && acknak_ready_i) begin
          if (an_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL acknak_unexpected: got en=%0h num=%0h, expected no request",
                     acknak_seq_en_o, acknak_seq_num_o);
          end else begin
            a = an_q.pop_front();
            check("acknak", 256'({acknak_seq_en_o, acknak_seq_num_o}), 256'({a.en, a.num}));
          end
        end
      end
    end
  endtask

  initial begin
    int cnt, held;
    srst           = 1'b1;
    DLCMSM_i       = DLCMSM_INACTIVE;
    data_i         = '0;
    data_valid_i   = 1'b0;
    acknak_ready_i = 1'b1;
    fork
      monitor();
    join_none

    // Reset values
    step(3);
    check("rst_valid", 256'(tlp_valid_o), '0);
    check("rst_sop_eop", 256'({tlp_sop_o, tlp_eop_o}), '0);
    check("rst_ok_drop", 256'({tlp_ok_o, tlp_drop_o}), '0);
    check("rst_last_dw", 256'(tlp_last_dw_o), '0);
    check("rst_data", tlp_data_o, '0);
    check("rst_en", 256'(acknak_seq_en_o), '0);
    check("rst_num", 256'(acknak_seq_num_o), '0);
    srst = 1'b0;
    step(1);
    DLCMSM_i = DLCMSM_ACTIVE;
    step(1);
    check("init_num", 256'(acknak_seq_num_o), 256'(16'h0FFF));

    // Good single-beat TLP, ACK after the latency window
    an_q.push_back({ACKNAK_ACK, 16'h0000});
    send_tlp(6, 0, 1'b0, MODE_OK, BODY, 0);
    check("t1_num_after_ok", 256'(acknak_seq_num_o), 256'(16'h0000));
    cnt = 0;
    while (acknak_seq_en_o != ACKNAK_ACK && cnt < 100) begin
      step(1);
      cnt++;
    end
    check("t1_ack_latency", 256'(cnt), 256'(64));
    wait_drain(20);

    // Bad LCRC on a 3-beat TLP: one NAK, the repeat is suppressed
    link_reset();
    an_q.push_back({ACKNAK_NAK, 16'h0FFF});
    send_tlp(20, 0, 1'b1, MODE_DROP, BODY, 0);
    send_tlp(20, 0, 1'b1, MODE_DROP, BODY, 0);
    step(10);
    wait_drain(20);

    // Duplicate and gap against NRS=5
    link_reset();
    for (int s = 0; s < 5; s++) send_tlp(6, s, 1'b0, MODE_OK, BODY, 0);
    an_q.push_back({ACKNAK_ACK, 16'h0004});
    send_tlp(6, 3, 1'b0, MODE_DROP, BODY, 0);
    check("t3_dup_immediate", 256'(acknak_seq_en_o), 256'(ACKNAK_ACK));
    an_q.push_back({ACKNAK_NAK, 16'h0004});
    send_tlp(6, 9, 1'b0, MODE_DROP, BODY, 0);
    wait_drain(20);

    // Sequence wrap 4095 -> 0
    link_reset();
    acknak_ready_i = 1'b0;
    for (int s = 0; s < 4095; s++) send_tlp(6, s, 1'b0, MODE_OK, BODY, 0);
    step(70);
    an_q.push_back({ACKNAK_ACK, 16'd4094});
    acknak_ready_i = 1'b1;
    step(2);
    send_tlp(6, 4095, 1'b0, MODE_OK, BODY, 0);
    check("t4_wrap_num", 256'(acknak_seq_num_o), 256'(16'h0FFF));
    an_q.push_back({ACKNAK_ACK, 16'h0000});
    send_tlp(6, 0, 1'b0, MODE_OK, BODY, 0);
    wait_drain(100);

    // Bad lengths: LEN=2 NAK held without ready, oversize swallowed whole
    link_reset();
    acknak_ready_i = 1'b0;
    an_q.push_back({ACKNAK_NAK, 16'h0FFF});
    send_tlp(2, 0, 1'b0, MODE_NONE, BODY, 0);
    check("t5_nak_raised", 256'(acknak_seq_en_o), 256'(ACKNAK_NAK));
    held = 0;
    repeat (10) begin
      step(1);
      if (acknak_seq_en_o == ACKNAK_NAK) held++;
    end
    check("t5_nak_held", 256'(held), 256'(10));
    acknak_ready_i = 1'b1;
    step(2);
    send_tlp(135, 0, 1'b0, MODE_NONE, 32'h0000_006F, 0);
    an_q.push_back({ACKNAK_ACK, 16'h0000});
    send_tlp(6, 0, 1'b0, MODE_OK, BODY, 0);
    wait_drain(100);

    // Link leaves ACTIVE mid-TLP
    link_reset();
    send_tlp(6, 0, 1'b0, MODE_OK, BODY, 0);
    send_tlp(20, 1, 1'b0, MODE_DROP, BODY, 2);
    tl_q.push_back('{data: '0, sop: 1'b0, eop: 1'b1, last_dw: 3'd0, ok: 1'b0, drop: 1'b1});
    DLCMSM_i = DLCMSM_INACTIVE;
    step(1);
    check("t6_num_cleared", 256'(acknak_seq_num_o), 256'(16'h0FFF));
    check("t6_en_idle", 256'(acknak_seq_en_o), 256'(ACKNAK_IDLE));
    step(80);
    wait_drain(10);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
